// File: rtl/ysyx_220053_lsu_pkg.sv
// rtl/ysyx_220053_lsu_pkg.sv - shared encodings and helpers for the load/store unit
// Holds the mem_op encodings, the LSU state enum, byte-lane masks for each
// access size, sign-extension widths and small decode helpers.
package ysyx_220053_lsu_pkg;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_D  = 3'b011;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;
  localparam logic [2:0] OP_WU = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} lsu_state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} lsu_size_e;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  localparam int EXT_B = 8;
  localparam int EXT_H = 16;
  localparam int EXT_W = 32;

  // 3'b111 is not a defined op; it falls into the default and acts as D.
  function automatic lsu_size_e op_size(input logic [2:0] op);
    case (op)
      OP_B, OP_BU: return SZ_B;
      OP_H, OP_HU: return SZ_H;
      OP_W, OP_WU: return SZ_W;
      OP_D:        return SZ_D;
      default:     return SZ_D;
    endcase
  endfunction

  function automatic logic op_unsigned(input logic [2:0] op);
    return (op == OP_BU) || (op == OP_HU) || (op == OP_WU);
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] op_lo_mask(input logic [2:0] op);
    case (op_size(op))
      SZ_B:    return 3'b000;
      SZ_H:    return 3'b001;
      SZ_W:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_220053_lsu_align.sv
// rtl/ysyx_220053_lsu_align.sv - combinational byte-lane shift/mask and load extract/extend
// Ports:
//   mem_op     access size/sign code
//   addr_lo    effective address bits [2:0]
//   store_data rs2 value, shifted onto its byte lanes -> wdata
//   rdata      64-bit bus read data, extracted and extended -> load_data
//   wmask      byte-lane strobe for the access
module ysyx_220053_lsu_align
  import ysyx_220053_lsu_pkg::*;
(
  input  logic [2:0]  mem_op,
  input  logic [2:0]  addr_lo,
  input  logic [63:0] store_data,
  input  logic [63:0] rdata,
  output logic [63:0] wdata,
  output logic [7:0]  wmask,
  output logic [63:0] load_data
);

  logic [2:0]  a;
  logic [63:0] sh;
  logic        sgn;

  // Misaligned low bits are dropped so the access stays inside one dword.
  assign a   = addr_lo & ~op_lo_mask(mem_op);
  assign sgn = ~op_unsigned(mem_op);

  always_comb begin
    wdata     = store_data << {a, 3'b000};
    sh        = rdata >> {a, 3'b000};
    wmask     = MASK_D;
    load_data = sh;
    case (op_size(mem_op))
      SZ_B: begin
        wmask     = MASK_B << a;
        load_data = {{(64-EXT_B){sgn & sh[EXT_B-1]}}, sh[EXT_B-1:0]};
      end
      SZ_H: begin
        wmask     = MASK_H << a;
        load_data = {{(64-EXT_H){sgn & sh[EXT_H-1]}}, sh[EXT_H-1:0]};
      end
      SZ_W: begin
        wmask     = MASK_W << a;
        load_data = {{(64-EXT_W){sgn & sh[EXT_W-1]}}, sh[EXT_W-1:0]};
      end
      default: begin
        wmask     = MASK_D;
        load_data = sh;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_220053_lsu.sv
// rtl/ysyx_220053_lsu.sv - memory-access stage: FSM, input latches, bus timeout
// Optional: define YSYX_220053_LSU_MISALIGN_CHECK_EN to reject misaligned
// H/W/D accesses with err=1 instead of truncating their address.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        op handshake from EX (alu_res, store_data,
//                            mem_rd, mem_wr, mem_op, rd_in)
//   mwb_block                stall to EX while not idle
//   bus_req_*/bus_addr/we/wdata/wmask  request channel of the data bus
//   bus_resp_valid/bus_rdata response channel of the data bus
//   out_valid/out_ready      writeback record to WB (wb_data, wb_rd, wb_en, err)
module ysyx_220053_lsu
  import ysyx_220053_lsu_pkg::*;
#(
  parameter int          ADDR_W  = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [63:0]       alu_res,
  input  logic [63:0]       store_data,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [2:0]        mem_op,
  input  logic [4:0]        rd_in,
  output logic              mwb_block,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic [63:0]       bus_wdata,
  output logic [7:0]        bus_wmask,
  input  logic              bus_resp_valid,
  input  logic [63:0]       bus_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       wb_data,
  output logic [4:0]        wb_rd,
  output logic              wb_en,
  output logic              err
);

  lsu_state_e  state, state_n;
  logic [63:0] addr_q, sdata_q, wb_data_q;
  logic [2:0]  op_q;
  logic [4:0]  rd_q, wb_rd_q;
  logic        st_q, wb_en_q, err_q;
  logic [31:0] cnt_q;
  logic [63:0] al_wdata, al_load;
  logic [7:0]  al_wmask;
  logic        is_mem, misalign, timeout_hit, in_req;

  assign is_mem = mem_rd | mem_wr;

`ifdef YSYX_220053_LSU_MISALIGN_CHECK_EN
  assign misalign = is_mem && ((alu_res[2:0] & op_lo_mask(mem_op)) != 3'b000);
`else
  assign misalign = 1'b0;
`endif

  // cnt_q counts completed WAIT cycles; the TIMEOUT-th one gives up.
  assign timeout_hit = (TIMEOUT != 0) && ((cnt_q + 32'd1) == TIMEOUT);

  ysyx_220053_lsu_align u_align (
    .mem_op     (op_q),
    .addr_lo    (addr_q[2:0]),
    .store_data (sdata_q),
    .rdata      (bus_rdata),
    .wdata      (al_wdata),
    .wmask      (al_wmask),
    .load_data  (al_load)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n       = state;
    in_ready      = 1'b0;
    mwb_block     = 1'b1;
    bus_req_valid = 1'b0;
    out_valid     = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready  = 1'b1;
        mwb_block = 1'b0;
        if (in_valid) state_n = (!is_mem || misalign) ? S_DONE : S_REQ;
      end
      S_REQ: begin
        bus_req_valid = 1'b1;
        // Stores are posted: the request handshake completes them.
        if (bus_req_ready) state_n = st_q ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (bus_resp_valid || timeout_hit) state_n = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      sdata_q   <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      st_q      <= 1'b0;
      cnt_q     <= '0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
      wb_en_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            addr_q  <= alu_res;
            sdata_q <= store_data;
            op_q    <= mem_op;
            rd_q    <= rd_in;
            st_q    <= mem_wr;
            cnt_q   <= '0;
            err_q   <= misalign;
            if (!is_mem) begin
              wb_data_q <= alu_res;
              wb_rd_q   <= rd_in;
              wb_en_q   <= (rd_in != 5'd0);
            end else begin
              wb_data_q <= '0;
              wb_rd_q   <= mem_wr ? 5'd0 : rd_in;
              wb_en_q   <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          if (bus_resp_valid) begin
            wb_data_q <= al_load;
            wb_en_q   <= (rd_q != 5'd0);
          end else if (timeout_hit) begin
            err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_req    = (state == S_REQ);
  assign bus_addr  = in_req ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
  assign bus_we    = in_req & st_q;
  assign bus_wdata = in_req ? al_wdata : '0;
  assign bus_wmask = in_req ? al_wmask : '0;

  assign wb_data = wb_data_q;
  assign wb_rd   = wb_rd_q;
  assign wb_en   = wb_en_q;
  assign err     = err_q;

endmodule

// File: tb/tb_ysyx_220053_lsu.sv
// tb/tb_ysyx_220053_lsu.sv - self-checking bench for ysyx_220053_lsu
module tb_ysyx_220053_lsu;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [63:0] alu_res, store_data;
  logic        mem_rd, mem_wr;
  logic [2:0]  mem_op;
  logic [4:0]  rd_in;
  logic        mwb_block, bus_req_valid, bus_req_ready, bus_we;
  logic [63:0] bus_addr, bus_wdata, bus_rdata;
  logic [7:0]  bus_wmask;
  logic        bus_resp_valid, out_valid, out_ready, wb_en, err;
  logic [63:0] wb_data;
  logic [4:0]  wb_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_220053_lsu #(.ADDR_W(64), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_res(alu_res), .store_data(store_data), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_op(mem_op), .rd_in(rd_in), .mwb_block(mwb_block),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_addr(bus_addr),
    .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
    .bus_resp_valid(bus_resp_valid), .bus_rdata(bus_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_en(wb_en), .err(err)
  );

  typedef struct {
    logic [63:0] alu, sdata, rdata;
    logic        mrd, mwr;
    logic [2:0]  op;
    logic [4:0]  rd;
    int          req_dly, resp_dly, out_dly;
    logic        e_req;
    logic [63:0] e_addr;
    logic [7:0]  e_mask;
    logic [63:0] e_wdata, e_wb;
    logic        e_en, e_err;
    logic [4:0]  e_rd;
    int          e_lat;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t v(input logic [63:0] alu, sdata, rdata, input logic mrd, mwr,
                             input logic [2:0] op, input logic [4:0] rd, input int rq, rs, od,
                             input logic e_req, input logic [63:0] e_addr, input logic [7:0] e_mask,
                             input logic [63:0] e_wdata, e_wb, input logic e_en, e_err,
                             input logic [4:0] e_rd, input int e_lat);
    vec_t r;
    r.alu = alu; r.sdata = sdata; r.rdata = rdata; r.mrd = mrd; r.mwr = mwr; r.op = op; r.rd = rd;
    r.req_dly = rq; r.resp_dly = rs; r.out_dly = od;
    r.e_req = e_req; r.e_addr = e_addr; r.e_mask = e_mask; r.e_wdata = e_wdata; r.e_wb = e_wb;
    r.e_en = e_en; r.e_err = e_err; r.e_rd = e_rd; r.e_lat = e_lat;
    return r;
  endfunction

  // Reference: access size in bytes, lanes picked byte by byte from the dword.
  function automatic vec_t model(input vec_t t);
    vec_t r;
    int nb, a;
    logic [63:0] val;
    r = t;
    case (t.op)
      3'd0, 3'd4: nb = 1;
      3'd1, 3'd5: nb = 2;
      3'd2, 3'd6: nb = 4;
      default:    nb = 8;
    endcase
    a = int'(t.alu[2:0]);
    r.e_req = 0; r.e_addr = 0; r.e_mask = 0; r.e_wdata = 0; r.e_wb = 0;
    r.e_en = 0; r.e_err = 0; r.e_lat = 0;
    r.e_rd = t.mwr ? 5'd0 : t.rd;
    if (!t.mrd && !t.mwr) begin
      r.e_wb = t.alu; r.e_en = (t.rd != 0); r.e_rd = t.rd;
      return r;
    end
`ifdef YSYX_220053_LSU_MISALIGN_CHECK_EN
    if (a % nb != 0) begin
      r.e_err = 1;
      return r;
    end
`endif
    a = a - a % nb;
    r.e_req = 1;
    r.e_addr = t.alu & ~64'h7;
    for (int i = 0; i < nb; i++) r.e_mask[a+i] = 1'b1;
    r.e_wdata = t.sdata << (8 * a);
    if (t.mwr) begin
      r.e_lat = t.req_dly + 1;
      return r;
    end
    if (t.resp_dly < 0 || t.resp_dly >= TMO) begin
      r.e_err = 1; r.e_lat = t.req_dly + 1 + TMO;
      return r;
    end
    val = '0;
    for (int i = 0; i < nb; i++) val[8*i +: 8] = t.rdata[8*(a+i) +: 8];
    if (t.op < 3'd3 && val[8*nb-1]) for (int j = 8 * nb; j < 64; j++) val[j] = 1'b1;
    r.e_wb = val; r.e_en = (t.rd != 0); r.e_lat = t.req_dly + t.resp_dly + 2;
    return r;
  endfunction

  task automatic apply_vec(input vec_t t, input string nm);
    logic seen_req, seen_out, fin, hs, busy_ok, stable_ok;
    logic [63:0] addr_c, wd_c, wb_c;
    logic [7:0]  mk_c;
    logic        we_c, en_c, err_c;
    logic [4:0]  rd_c;
    int lat, rcnt, wcnt, ocnt;
    seen_req = 0; seen_out = 0; fin = 0; hs = 0; busy_ok = 1; stable_ok = 1;
    addr_c = 0; wd_c = 0; wb_c = 0; mk_c = 0; we_c = 0; en_c = 0; err_c = 0; rd_c = 0;
    lat = -1; rcnt = 0; wcnt = 0; ocnt = 0;
    @(negedge clk);
    chk({nm, ".in_ready_idle"}, in_ready, 1);
    in_valid = 1; alu_res = t.alu; store_data = t.sdata; mem_rd = t.mrd; mem_wr = t.mwr;
    mem_op = t.op; rd_in = t.rd;
    @(negedge clk);
    in_valid = 0; alu_res = {$urandom, $urandom}; store_data = {$urandom, $urandom};
    mem_op = 3'($urandom); rd_in = 5'($urandom);
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      bus_req_ready = 0; bus_resp_valid = 0; out_ready = 0;
      bus_rdata = {$urandom, $urandom};
      if (in_ready !== 1'b0 || mwb_block !== 1'b1) busy_ok = 0;
      if (out_valid) begin
        if (!seen_out) begin
          seen_out = 1; lat = cyc; wb_c = wb_data; en_c = wb_en; rd_c = wb_rd; err_c = err;
        end else if (wb_data !== wb_c || wb_en !== en_c || wb_rd !== rd_c || err !== err_c) begin
          stable_ok = 0;
        end
        if (ocnt >= t.out_dly) begin out_ready = 1; fin = 1; end
        ocnt++;
      end
      if (bus_req_valid) begin
        if (!seen_req) begin
          addr_c = bus_addr; wd_c = bus_wdata; mk_c = bus_wmask; we_c = bus_we;
        end else if (bus_addr !== addr_c || bus_wdata !== wd_c || bus_wmask !== mk_c || bus_we !== we_c) begin
          stable_ok = 0;
        end
        seen_req = 1;
        if (rcnt >= t.req_dly) begin bus_req_ready = 1; hs = 1; end
        rcnt++;
      end else if (hs && !t.mwr) begin
        if (wcnt == t.resp_dly) begin bus_resp_valid = 1; bus_rdata = t.rdata; end
        wcnt++;
      end
      @(negedge clk);
    end
    bus_req_ready = 0; bus_resp_valid = 0; out_ready = 0;
    chk({nm, ".completed"}, fin, 1);
    chk({nm, ".in_ready_after"}, in_ready, 1);
    chk({nm, ".out_valid_after"}, out_valid, 0);
    chk({nm, ".busy"}, busy_ok, 1);
    chk({nm, ".stable"}, stable_ok, 1);
    chk({nm, ".bus_req"}, seen_req, t.e_req);
    if (t.e_req) begin
      chk({nm, ".bus_addr"}, addr_c, t.e_addr);
      chk({nm, ".bus_wmask"}, mk_c, t.e_mask);
      chk({nm, ".bus_we"}, we_c, t.mwr);
      if (t.mwr) chk({nm, ".bus_wdata"}, wd_c, t.e_wdata);
    end
    chk({nm, ".wb_en"}, en_c, t.e_en);
    chk({nm, ".err"}, err_c, t.e_err);
    chk({nm, ".wb_rd"}, rd_c, t.e_rd);
    chk({nm, ".latency"}, 64'(lat), 64'(t.e_lat));
    if (!t.mwr && !t.e_err) chk({nm, ".wb_data"}, wb_c, t.e_wb);
  endtask

  initial begin
    vec_t rv;
    logic seen;
    int kind, rs;

    tbl[0]  = v(64'h1234, 0, 0, 0, 0, 3'd0, 5'd5, 0, 0, 0,
                0, 0, 0, 0, 64'h1234, 1, 0, 5'd5, 0);
    tbl[1]  = v(64'hDEADBEEF00000001, 0, 0, 0, 0, 3'd2, 5'd0, 0, 0, 1,
                0, 0, 0, 0, 64'hDEADBEEF00000001, 0, 0, 5'd0, 0);
    tbl[2]  = v(64'h80000003, 0, 64'h0000000080000000, 1, 0, 3'd0, 5'd10, 0, 0, 0,
                1, 64'h80000000, 8'h08, 0, 64'hFFFFFFFFFFFFFF80, 1, 0, 5'd10, 2);
    tbl[3]  = v(64'h80000003, 0, 64'h0000000080000000, 1, 0, 3'd4, 5'd10, 0, 0, 0,
                1, 64'h80000000, 8'h08, 0, 64'h80, 1, 0, 5'd10, 2);
    tbl[4]  = v(64'h80000006, 64'hBEEF, 0, 0, 1, 3'd1, 5'd9, 0, 0, 0,
                1, 64'h80000000, 8'hC0, 64'hBEEF000000000000, 0, 0, 0, 5'd0, 1);
`ifdef YSYX_220053_LSU_MISALIGN_CHECK_EN
    tbl[5]  = v(64'h80000002, 0, 64'h11223344AABBCCDD, 1, 0, 3'd2, 5'd3, 0, 0, 0,
                0, 0, 0, 0, 0, 0, 1, 5'd3, 0);
`else
    tbl[5]  = v(64'h80000002, 0, 64'h11223344AABBCCDD, 1, 0, 3'd2, 5'd3, 0, 0, 0,
                1, 64'h80000000, 8'h0F, 0, 64'hFFFFFFFFAABBCCDD, 1, 0, 5'd3, 2);
`endif
    tbl[6]  = v(64'h80000010, 0, 64'h0123456789ABCDEF, 1, 0, 3'd3, 5'd12, 4, 2, 3,
                1, 64'h80000010, 8'hFF, 0, 64'h0123456789ABCDEF, 1, 0, 5'd12, 8);
    tbl[7]  = v(64'h80000020, 0, 0, 1, 0, 3'd2, 5'd4, 0, -1, 0,
                1, 64'h80000020, 8'h0F, 0, 0, 0, 1, 5'd4, 9);
    tbl[8]  = v(64'h80000008, 64'hCAFEF00D12345678, 0, 1, 1, 3'd3, 5'd6, 1, 0, 0,
                1, 64'h80000008, 8'hFF, 64'hCAFEF00D12345678, 0, 0, 0, 5'd0, 2);
    tbl[9]  = v(64'h80000006, 0, 64'h8001000000000000, 1, 0, 3'd5, 5'd1, 0, 0, 0,
                1, 64'h80000000, 8'hC0, 0, 64'h8001, 1, 0, 5'd1, 2);
    tbl[10] = v(64'h80000006, 0, 64'h8001000000000000, 1, 0, 3'd1, 5'd1, 0, 0, 0,
                1, 64'h80000000, 8'hC0, 0, 64'hFFFFFFFFFFFF8001, 1, 0, 5'd1, 2);
    tbl[11] = v(64'h80000018, 0, 64'h5555, 1, 0, 3'd3, 5'd0, 0, 1, 0,
                1, 64'h80000018, 8'hFF, 0, 64'h5555, 0, 0, 5'd0, 3);
    tbl[12] = v(64'h80000005, 64'hAB, 0, 0, 1, 3'd0, 5'd2, 2, 0, 1,
                1, 64'h80000000, 8'h20, 64'h0000AB0000000000, 0, 0, 0, 5'd0, 3);

    rst = 1; in_valid = 0; alu_res = 0; store_data = 0; mem_rd = 0; mem_wr = 0;
    mem_op = 0; rd_in = 0; bus_req_ready = 0; bus_resp_valid = 0; bus_rdata = 0; out_ready = 0;
    repeat (3) @(negedge clk);
    chk("reset.in_ready", in_ready, 1);
    chk("reset.mwb_block", mwb_block, 0);
    chk("reset.bus_req_valid", bus_req_valid, 0);
    chk("reset.out_valid", out_valid, 0);
    chk("reset.wb_en", wb_en, 0);
    chk("reset.err", err, 0);
    chk("reset.wb_data", wb_data, 0);
    chk("reset.wb_rd", wb_rd, 0);
    chk("reset.bus_addr", bus_addr, 0);
    chk("reset.bus_wmask", bus_wmask, 0);
    chk("reset.bus_we", bus_we, 0);
    rst = 0;

    for (int i = 0; i < 13; i++) apply_vec(tbl[i], $sformatf("vec%0d", i));

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 2);
      rv.mrd = (kind == 1); rv.mwr = (kind == 2);
      if ($urandom_range(0, 9) == 0) begin rv.mrd = 1; rv.mwr = 1; end
      rv.op = 3'($urandom_range(0, 7));
      rv.rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rv.alu = (rv.mrd || rv.mwr) ? 64'h80000000 + 64'($urandom_range(0, 255)) : {$urandom, $urandom};
      rv.sdata = {$urandom, $urandom};
      rv.rdata = {$urandom, $urandom};
      rv.req_dly = $urandom_range(0, 3);
      rs = $urandom_range(0, 9);
      rv.resp_dly = (rs == 0) ? -1 : (rs == 1) ? TMO - 1 : $urandom_range(0, 3);
      rv.out_dly = $urandom_range(0, 2);
      apply_vec(model(rv), $sformatf("rand%0d", n));
    end

    // Reset while a load is waiting for its response.
    @(negedge clk);
    in_valid = 1; mem_rd = 1; mem_wr = 0; alu_res = 64'h80000040; mem_op = 3'd3; rd_in = 5'd7;
    @(negedge clk);
    in_valid = 0; mem_rd = 0;
    chk("rst_wait.bus_req_valid", bus_req_valid, 1);
    bus_req_ready = 1;
    @(negedge clk);
    bus_req_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_wait.busy", mwb_block, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_wait.in_ready", in_ready, 1);
    chk("rst_wait.mwb_block", mwb_block, 0);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      bus_resp_valid = (c == 1); bus_rdata = 64'hFFFF;
      out_ready = 1;
      @(negedge clk);
      if (out_valid || bus_req_valid) seen = 1;
    end
    bus_resp_valid = 0; out_ready = 0;
    chk("rst_wait.no_writeback", seen, 0);
    chk("rst_wait.idle", in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
